// File: rtl/apu_dispatch_pkg.sv
// Shared-APU configuration for the cluster dispatcher: operand/flag widths,
// the core-ID type and the per-core request payload.
package apu_dispatch_pkg;

    localparam int APU_NB_CORES     = 4;
    localparam int NARGS_CPU        = 3;
    localparam int WOP_CPU          = 6;
    localparam int NUSFLAGS_CPU     = 5;
    localparam int NDSFLAGS_CPU     = 15;
    localparam int APU_WDATA        = 32;
    localparam int APU_MAX_INFLIGHT = 4;

    localparam int CORE_ID_W = (APU_NB_CORES > 1) ? $clog2(APU_NB_CORES) : 1;

    typedef logic [CORE_ID_W-1:0] core_id_t;

    typedef struct packed {
        logic [NARGS_CPU-1:0][APU_WDATA-1:0] operands;
        logic [WOP_CPU-1:0]                  op;
        logic [NUSFLAGS_CPU-1:0]             flags;
    } apu_req_t;

endpackage

// File: rtl/apu_tag_fifo.sv
// Small FIFO holding the issuing core ID of every operation accepted by the
// shared unit; supports push and pop in the same cycle even when full.
module apu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];

    // A pop frees the slot the push writes into, so a full FIFO may still push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apu_rr_dispatcher.sv
// Round-robin dispatcher from the cluster cores' APU ports onto one shared,
// in-order APU unit; results are steered back to the issuing core via a tag FIFO.
module apu_rr_dispatcher
    import apu_dispatch_pkg::*;
#(
    parameter int NB_CORES     = APU_NB_CORES,
    parameter int NARGS        = NARGS_CPU,
    parameter int WOP          = WOP_CPU,
    parameter int NUSFLAGS     = NUSFLAGS_CPU,
    parameter int NDSFLAGS     = NDSFLAGS_CPU,
    parameter int WDATA        = APU_WDATA,
    parameter int MAX_INFLIGHT = APU_MAX_INFLIGHT
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NB_CORES-1:0]             core_req_i,
    output logic [NB_CORES-1:0]             core_gnt_o,
    input  logic [NB_CORES*NARGS*WDATA-1:0] core_operands_i,
    input  logic [NB_CORES*WOP-1:0]         core_op_i,
    input  logic [NB_CORES*NUSFLAGS-1:0]    core_flags_i,
    output logic [NB_CORES-1:0]             core_rvalid_o,
    output logic [WDATA-1:0]                core_rdata_o,
    output logic [NDSFLAGS-1:0]             core_rflags_o,
    output logic                            unit_req_o,
    input  logic                            unit_gnt_i,
    output logic [NARGS*WDATA-1:0]          unit_operands_o,
    output logic [WOP-1:0]                  unit_op_o,
    output logic [NUSFLAGS-1:0]             unit_flags_o,
    input  logic                            unit_rvalid_i,
    input  logic [WDATA-1:0]                unit_rdata_i,
    input  logic [NDSFLAGS-1:0]             unit_rflags_i,
    output logic                            err_o
);

    localparam int IDW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int PW  = NARGS * WDATA;

    logic [IDW-1:0] rr_q;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] fifo_head;
    logic           any_req;
    logic           fifo_full;
    logic           fifo_empty;
    logic           full_eff;
    logic           handshake;
    logic           pop;

    // First requester at or after rr_q, wrapping; defaults to rr_q when idle.
    always_comb begin : find_winner
        int             idx;
        logic [IDW-1:0] cand;
        logic           found;
        winner = rr_q;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NB_CORES) begin
                idx = idx - NB_CORES;
            end
            cand = IDW'(idx);
            if (!found && core_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req    = |core_req_i;
    assign pop        = unit_rvalid_i & ~fifo_empty;
    assign full_eff   = fifo_full & ~pop;
    assign unit_req_o = any_req & ~full_eff;
    assign handshake  = unit_req_o & unit_gnt_i;

    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        if (handshake) begin
            core_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            core_rvalid_o[fifo_head] = 1'b1;
        end
    end

    always_comb begin
        unit_operands_o = '0;
        unit_op_o       = '0;
        unit_flags_o    = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            if (IDW'(c) == winner) begin
                unit_operands_o = core_operands_i[c*PW +: PW];
                unit_op_o       = core_op_i[c*WOP +: WOP];
                unit_flags_o    = core_flags_i[c*NUSFLAGS +: NUSFLAGS];
            end
        end
    end

    assign core_rdata_o  = unit_rdata_i;
    assign core_rflags_o = unit_rflags_i;

    // A result with no matching tag cannot be routed; it is dropped and flagged until reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            err_o <= 1'b0;
        end else begin
            if (handshake) begin
                rr_q <= (winner == IDW'(NB_CORES - 1)) ? '0 : winner + 1'b1;
            end
            if (unit_rvalid_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    apu_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (IDW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_apu_rr_dispatcher.sv
// Directed bench for apu_rr_dispatcher: expected grants and routed results are
// queued by the stimulus and checked by a separate negedge monitor.
module tb_apu_rr_dispatcher;
    import apu_dispatch_pkg::*;

    localparam int NC = APU_NB_CORES;
    localparam int NA = NARGS_CPU;
    localparam int WD = APU_WDATA;
    localparam int WO = WOP_CPU;
    localparam int NU = NUSFLAGS_CPU;
    localparam int ND = NDSFLAGS_CPU;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NC-1:0]     core_req_i = '0;
    logic [NC-1:0]     core_gnt_o;
    logic [NC*NA*WD-1:0] core_operands_i;
    logic [NC*WO-1:0]  core_op_i;
    logic [NC*NU-1:0]  core_flags_i;
    logic [NC-1:0]     core_rvalid_o;
    logic [WD-1:0]     core_rdata_o;
    logic [ND-1:0]     core_rflags_o;
    logic              unit_req_o;
    logic              unit_gnt_i = 1'b0;
    logic [NA*WD-1:0]  unit_operands_o;
    logic [WO-1:0]     unit_op_o;
    logic [NU-1:0]     unit_flags_o;
    logic              unit_rvalid_i;
    logic [WD-1:0]     unit_rdata_i;
    logic [ND-1:0]     unit_rflags_i;
    logic              err_o;

    // Stand-in for the shared unit: fixed 4-cycle latency, returns operand 0.
    logic              unit_auto = 1'b0;
    logic              man_rvalid = 1'b0;
    logic [WD-1:0]     man_rdata = '0;
    logic [ND-1:0]     man_rflags = '0;
    logic [3:0]        pipe_v = '0;
    logic [WD-1:0]     pipe_d [4];
    logic              hs_rec = 1'b0;
    logic [WD-1:0]     d_rec = '0;

    typedef struct packed {
        core_id_t      core;
        logic [WD-1:0] data;
        logic [ND-1:0] flags;
    } ret_t;

    core_id_t exp_gnt [$];
    ret_t     exp_ret [$];
    int       checks = 0;
    int       passes = 0;

    assign unit_rvalid_i = unit_auto ? pipe_v[3] : man_rvalid;
    assign unit_rdata_i  = unit_auto ? pipe_d[3] : man_rdata;
    assign unit_rflags_i = unit_auto ? ND'(pipe_d[3]) : man_rflags;

    always #5 clk = ~clk;

    apu_rr_dispatcher dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_operands_i (core_operands_i),
        .core_op_i       (core_op_i),
        .core_flags_i    (core_flags_i),
        .core_rvalid_o   (core_rvalid_o),
        .core_rdata_o    (core_rdata_o),
        .core_rflags_o   (core_rflags_o),
        .unit_req_o      (unit_req_o),
        .unit_gnt_i      (unit_gnt_i),
        .unit_operands_o (unit_operands_o),
        .unit_op_o       (unit_op_o),
        .unit_flags_o    (unit_flags_o),
        .unit_rvalid_i   (unit_rvalid_i),
        .unit_rdata_i    (unit_rdata_i),
        .unit_rflags_i   (unit_rflags_i),
        .err_o           (err_o)
    );

    function automatic logic [WD-1:0] opnd(input int c, input int a);
        return 32'hA0A0_0000 | WD'(a << 8) | WD'(c);
    endfunction

    function automatic logic [WO-1:0] opc(input int c);
        return WO'(32 + c);
    endfunction

    function automatic logic [NU-1:0] flg(input int c);
        return NU'(c + 1);
    endfunction

    function automatic logic [NC-1:0] onehot(input core_id_t c);
        logic [NC-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NC-1:0] req, input logic gnt);
        core_req_i = req;
        unit_gnt_i = gnt;
    endtask

    task automatic setReturn(input logic rv, input logic [WD-1:0] rd, input logic [ND-1:0] rf);
        man_rvalid = rv;
        man_rdata  = rd;
        man_rflags = rf;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectGrant(input int c);
        exp_gnt.push_back(core_id_t'(c));
    endtask

    task automatic expectReturn(input int c, input logic [WD-1:0] d, input logic [ND-1:0] f);
        ret_t r;
        r.core  = core_id_t'(c);
        r.data  = d;
        r.flags = f;
        exp_ret.push_back(r);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((exp_ret.size() != 0 || exp_gnt.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        checkOutput("drain_left", 64'(exp_ret.size() + exp_gnt.size()), 64'd0);
        exp_ret.delete();
        exp_gnt.delete();
    endtask

    always @(posedge clk) begin
        #1;
        pipe_v    = {pipe_v[2:0], hs_rec & unit_auto};
        pipe_d[3] = pipe_d[2];
        pipe_d[2] = pipe_d[1];
        pipe_d[1] = pipe_d[0];
        pipe_d[0] = d_rec;
    end

    // Monitor: pops the scoreboard whenever the DUT grants or returns a result.
    always @(negedge clk) begin
        ret_t     r;
        core_id_t g;
        hs_rec = unit_req_o & unit_gnt_i;
        d_rec  = unit_operands_o[WD-1:0];
        if (core_gnt_o != '0) begin
            if (exp_gnt.size() == 0) begin
                checkOutput("unexpected_gnt", 64'(core_gnt_o), 64'd0);
            end else begin
                g = exp_gnt.pop_front();
                checkOutput("gnt", 64'(core_gnt_o), 64'(onehot(g)));
            end
        end
        if (core_rvalid_o != '0) begin
            if (exp_ret.size() == 0) begin
                checkOutput("unexpected_rvalid", 64'(core_rvalid_o), 64'd0);
            end else begin
                r = exp_ret.pop_front();
                checkOutput("ret_core", 64'(core_rvalid_o), 64'(onehot(r.core)));
                checkOutput("ret_data", 64'(core_rdata_o), 64'(r.data));
                checkOutput("ret_flags", 64'(core_rflags_o), 64'(r.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < NA; a++) begin
                core_operands_i[(c*NA+a)*WD +: WD] = opnd(c, a);
            end
            core_op_i[c*WO +: WO]    = opc(c);
            core_flags_i[c*NU +: NU] = flg(c);
        end
        for (int i = 0; i < 4; i++) pipe_d[i] = '0;

        // Reset state
        applyStimulus('0, 1'b0);
        setReturn(1'b0, 32'hDEAD_BEEF, 15'h1234);
        rst_ni = 1'b0;
        @(negedge clk);
        checkOutput("rst_gnt", 64'(core_gnt_o), 64'd0);
        checkOutput("rst_rvalid", 64'(core_rvalid_o), 64'd0);
        checkOutput("rst_unit_req", 64'(unit_req_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        checkOutput("rst_rdata_pass", 64'(core_rdata_o), 64'h0000_0000_DEAD_BEEF);
        checkOutput("rst_rflags_pass", 64'(core_rflags_o), 64'h1234);
        cycle();
        rst_ni = 1'b1;
        setReturn(1'b0, '0, '0);

        // All cores request, unit returns after 4 cycles
        unit_auto = 1'b1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(4'hF, 1'b1);
            expectGrant(k % 4);
            expectReturn(k % 4, opnd(k % 4, 0), ND'(k % 4));
            @(negedge clk);
            checkOutput("p1_unit_req", 64'(unit_req_o), 64'd1);
            cycle();
        end
        applyStimulus('0, 1'b1);
        waitDrain(12);
        checkOutput("p1_err", 64'(err_o), 64'd0);

        // Only core 2, unit silent: FIFO fills after 4 grants
        unit_auto = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0100, 1'b1);
            expectGrant(2);
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("p2_full_req", 64'(unit_req_o), 64'd0);
            checkOutput("p2_full_gnt", 64'(core_gnt_o), 64'd0);
            cycle();
        end
        setReturn(1'b1, 32'h1234_5678, 15'h0ABC);
        expectReturn(2, 32'h1234_5678, 15'h0ABC);
        expectGrant(2);
        @(negedge clk);
        checkOutput("p2_ret_frees_slot", 64'(unit_req_o), 64'd1);
        cycle();
        setReturn(1'b0, '0, '0);
        @(negedge clk);
        checkOutput("p2_full_again", 64'(unit_req_o), 64'd0);
        cycle();
        applyStimulus('0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            setReturn(1'b1, 32'h5555_0000 + WD'(k), ND'(k + 7));
            expectReturn(2, 32'h5555_0000 + WD'(k), ND'(k + 7));
            cycle();
        end
        setReturn(1'b0, '0, '0);
        waitDrain(4);
        checkOutput("p2_err", 64'(err_o), 64'd0);

        // Steer rr_q to 2 via core 1, then cores 1 and 3 compete
        unit_auto = 1'b1;
        applyStimulus(4'b0010, 1'b1);
        expectGrant(1);
        expectReturn(1, opnd(1, 0), ND'(1));
        cycle();
        applyStimulus(4'b1010, 1'b1);
        expectGrant(3);
        expectReturn(3, opnd(3, 0), ND'(3));
        cycle();
        expectGrant(1);
        expectReturn(1, opnd(1, 0), ND'(1));
        cycle();
        applyStimulus('0, 1'b1);
        waitDrain(10);

        // Unit stalls with core 0 requesting; rr_q is 2 and must hold
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0001, 1'b0);
            @(negedge clk);
            checkOutput("p4_no_gnt", 64'(core_gnt_o), 64'd0);
            checkOutput("p4_unit_req", 64'(unit_req_o), 64'd1);
            checkOutput("p4_opnd0", 64'(unit_operands_o[WD-1:0]), 64'(opnd(0, 0)));
            checkOutput("p4_opnd2", 64'(unit_operands_o[2*WD +: WD]), 64'(opnd(0, 2)));
            checkOutput("p4_op", 64'(unit_op_o), 64'(opc(0)));
            cycle();
        end
        applyStimulus(4'hF, 1'b0);
        @(negedge clk);
        checkOutput("p4_rr_hold_opnd", 64'(unit_operands_o[WD-1:0]), 64'(opnd(2, 0)));
        checkOutput("p4_rr_hold_flags", 64'(unit_flags_o), 64'(flg(2)));
        cycle();
        applyStimulus(4'b0001, 1'b1);
        expectGrant(0);
        expectReturn(0, opnd(0, 0), ND'(0));
        cycle();
        applyStimulus('0, 1'b1);
        @(negedge clk);
        checkOutput("p4_idle_sel_rr", 64'(unit_operands_o[WD-1:0]), 64'(opnd(1, 0)));
        checkOutput("p4_idle_req", 64'(unit_req_o), 64'd0);
        cycle();
        waitDrain(10);

        // Result with empty FIFO: dropped, err_o sticky
        unit_auto = 1'b0;
        setReturn(1'b1, 32'hBAD0_0001, 15'h0001);
        @(negedge clk);
        checkOutput("p5_rvalid_dropped", 64'(core_rvalid_o), 64'd0);
        checkOutput("p5_err_not_yet", 64'(err_o), 64'd0);
        cycle();
        setReturn(1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("p5_err_sticky", 64'(err_o), 64'd1);
            cycle();
        end

        // Reset with 3 ops in flight
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0001, 1'b1);
            expectGrant(0);
            cycle();
        end
        applyStimulus('0, 1'b1);
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
        @(negedge clk);
        checkOutput("p6_err_clr", 64'(err_o), 64'd0);
        checkOutput("p6_idle_req", 64'(unit_req_o), 64'd0);
        cycle();
        applyStimulus(4'hF, 1'b0);
        @(negedge clk);
        checkOutput("p6_rr_zero", 64'(unit_operands_o[WD-1:0]), 64'(opnd(0, 0)));
        cycle();
        applyStimulus('0, 1'b1);
        setReturn(1'b1, 32'h0BAD_0002, 15'h0002);
        @(negedge clk);
        checkOutput("p6_stale_dropped", 64'(core_rvalid_o), 64'd0);
        cycle();
        setReturn(1'b0, '0, '0);
        @(negedge clk);
        checkOutput("p6_stale_err", 64'(err_o), 64'd1);
        cycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0001, 1'b1);
            expectGrant(0);
            cycle();
        end
        @(negedge clk);
        checkOutput("p6_full_after_4", 64'(unit_req_o), 64'd0);
        cycle();
        applyStimulus('0, 1'b0);

        checkOutput("final_queues", 64'(exp_ret.size() + exp_gnt.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
